// File: rtl/n_term_wire_probe.sv
// Debug capture stage for the north terminal tile: registers the tapped north wires,
// freezes a snapshot on a masked pattern match and shifts it out LSB first.
module n_term_wire_probe #(
    parameter int WIDTH = 52,
    parameter int CNT_W = 6,
    parameter int TS_W  = 16
) (
    input  logic             UserCLK,
    input  logic             reset,
    input  logic [WIDTH-1:0] wires_i,
    input  logic             arm_i,
    input  logic [WIDTH-1:0] trig_mask_i,
    input  logic [WIDTH-1:0] trig_value_i,
    input  logic             rd_req_i,
    output logic             armed_o,
    output logic             captured_o,
    output logic             sdo_o,
    output logic             sdo_valid_o,
    output logic             done_o,
    output logic [TS_W-1:0]  ts_o
);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        CAPTURED,
        SHIFT
    } state_t;

    localparam logic [TS_W-1:0]  TS_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] s_q, cap_q, shift_q;
    logic [CNT_W-1:0] cnt_q;
    logic             last_q;   // set once the final bit has left; marks the done cycle
    logic [TS_W-1:0]  ts_cnt_q, ts_q;
    logic             match;

    assign match = ~|((s_q ^ trig_value_i) & trig_mask_i);
    assign ts_o  = ts_q;

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        armed_o     = 1'b0;
        captured_o  = 1'b0;
        sdo_valid_o = 1'b0;
        done_o      = 1'b0;
        case (state_q)
            IDLE: begin
                if (arm_i) state_d = ARMED;
            end
            ARMED: begin
                armed_o = 1'b1;
                if (match) state_d = CAPTURED;
            end
            CAPTURED: begin
                captured_o = 1'b1;
                if (rd_req_i)   state_d = SHIFT;
                else if (arm_i) state_d = ARMED;
            end
            SHIFT: begin
                sdo_valid_o = ~last_q;
                done_o      = last_q;
                if (last_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        sdo_o = sdo_valid_o & shift_q[0];
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge UserCLK) begin
        if (reset) begin
            state_q  <= IDLE;
            s_q      <= '0;
            cap_q    <= '0;
            shift_q  <= '0;
            cnt_q    <= '0;
            last_q   <= 1'b0;
            ts_cnt_q <= '0;
            ts_q     <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= wires_i;
            case (state_q)
                IDLE: begin
                    if (arm_i) ts_cnt_q <= '0;
                end
                ARMED: begin
                    if (ts_cnt_q != TS_MAX) ts_cnt_q <= ts_cnt_q + TS_W'(1);
                    if (match) begin
                        cap_q <= s_q;
                        ts_q  <= ts_cnt_q;
                    end
                end
                CAPTURED: begin
                    if (rd_req_i) begin
                        shift_q <= cap_q;
                        cnt_q   <= '0;
                        last_q  <= 1'b0;
                    end else if (arm_i) begin
                        ts_cnt_q <= '0;
                    end
                end
                SHIFT: begin
                    if (!last_q) begin
                        shift_q <= shift_q >> 1;
                        cnt_q   <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_LAST) last_q <= 1'b1;
                    end else begin
                        last_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_n_term_wire_probe.sv
// Directed bench for n_term_wire_probe: capture, readout, re-arm, ignored requests,
// timestamp saturation (small TS_W) and reset during readout.
module tb_n_term_wire_probe;

    localparam int W   = 52;
    localparam int TSW = 4;

    logic           UserCLK = 1'b0;
    logic           reset;
    logic [W-1:0]   wires_i, trig_mask_i, trig_value_i;
    logic           arm_i, rd_req_i;
    logic           armed_o, captured_o, sdo_o, sdo_valid_o, done_o;
    logic [TSW-1:0] ts_o;

    int n_checks = 0;
    int n_errors = 0;

    n_term_wire_probe #(.WIDTH(W), .CNT_W(6), .TS_W(TSW)) dut (
        .UserCLK      (UserCLK),
        .reset        (reset),
        .wires_i      (wires_i),
        .arm_i        (arm_i),
        .trig_mask_i  (trig_mask_i),
        .trig_value_i (trig_value_i),
        .rd_req_i     (rd_req_i),
        .armed_o      (armed_o),
        .captured_o   (captured_o),
        .sdo_o        (sdo_o),
        .sdo_valid_o  (sdo_valid_o),
        .done_o       (done_o),
        .ts_o         (ts_o)
    );

    always #5 UserCLK = ~UserCLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge UserCLK);
        #1;
    endtask

    // Capture a pattern with a full mask; the match lands on the first ARMED cycle.
    task automatic capture(input string tag, input logic [W-1:0] pat);
        wires_i      = pat;
        trig_mask_i  = '1;
        trig_value_i = pat;
        tick();
        arm_i = 1'b1;
        tick();
        arm_i = 1'b0;
        check({tag, "_armed"}, 64'(armed_o), 64'd1);
        tick();
        check({tag, "_captured"}, 64'(captured_o), 64'd1);
        check({tag, "_ts"}, 64'(ts_o), 64'd0);
    endtask

    // Requests readout from CAPTURED and collects the serial stream until done_o.
    task automatic readout(input logic hold, output logic [W-1:0] data,
                           output int nbits, output int ndone, output int nbad);
        data  = '0;
        nbits = 0;
        ndone = 0;
        nbad  = 0;
        rd_req_i = 1'b1;
        if (hold) arm_i = 1'b1;
        tick();
        if (!hold) rd_req_i = 1'b0;
        for (int c = 0; c < 2 * W + 10; c++) begin
            if (sdo_valid_o) begin
                if (nbits < W) data[nbits] = sdo_o;
                nbits++;
            end else if (sdo_o) begin
                nbad++;
            end
            if (done_o) begin
                ndone++;
                if (sdo_valid_o) nbad++;
                break;
            end
            tick();
        end
        tick();
    endtask

    task automatic check_readout(input string tag, input logic [W-1:0] exp, input logic hold);
        logic [W-1:0] data;
        int nbits, ndone, nbad;
        readout(hold, data, nbits, ndone, nbad);
        check({tag, "_bits"}, 64'(nbits), 64'(W));
        check({tag, "_data"}, 64'(data), 64'(exp));
        check({tag, "_done"}, 64'(ndone), 64'd1);
        check({tag, "_sdo_idle"}, 64'(nbad), 64'd0);
        check({tag, "_after"}, 64'({sdo_valid_o, done_o, armed_o, captured_o}), 64'd0);
    endtask

    initial begin
        reset        = 1'b1;
        arm_i        = 1'b1;
        rd_req_i     = 1'b0;
        trig_mask_i  = '0;
        trig_value_i = '0;
        wires_i      = W'({$urandom(), $urandom()});

        // 1. Reset with noisy wires and arm held high
        tick();
        wires_i = W'({$urandom(), $urandom()});
        tick();
        check("rst_armed", 64'(armed_o), 64'd0);
        check("rst_captured", 64'(captured_o), 64'd0);
        check("rst_sdo", 64'({sdo_valid_o, sdo_o, done_o}), 64'd0);
        check("rst_ts", 64'(ts_o), 64'd0);
        reset   = 1'b0;
        arm_i   = 1'b0;
        wires_i = '0;
        tick();
        check("idle_armed", 64'(armed_o), 64'd0);
        rd_req_i = 1'b1;
        tick();
        check("idle_rd_ignored", 64'({sdo_valid_o, captured_o, done_o}), 64'd0);
        rd_req_i = 1'b0;

        // 2. Masked nibble match, pattern applied on the 3rd ARMED cycle
        trig_mask_i  = W'(4'hF);
        trig_value_i = W'(4'h5);
        arm_i = 1'b1;
        tick();
        arm_i = 1'b0;
        check("m_armed_c1", 64'(armed_o), 64'd1);
        tick();
        tick();
        wires_i = 52'h9_8765_4321_0FE5;
        tick();
        check("m_not_yet", 64'(captured_o), 64'd0);
        tick();
        check("m_captured", 64'(captured_o), 64'd1);
        check("m_ts", 64'(ts_o), 64'd3);
        wires_i = '0;
        check_readout("m_rd", 52'h9_8765_4321_0FE5, 1'b0);

        // 3. Single set bit read out
        capture("c1", 52'h0_0000_0000_0001);
        check_readout("rd1", 52'h0_0000_0000_0001, 1'b0);

        // 4. Re-arm from CAPTURED discards A and times B from the re-arm
        capture("ca", 52'hA_AAAA_AAAA_AAAA);
        wires_i      = 52'h0_0F0F_0F0F_0F0F;
        trig_value_i = 52'h5_1234_5678_9ABC;
        arm_i = 1'b1;
        tick();
        arm_i = 1'b0;
        check("rearm_armed", 64'(armed_o), 64'd1);
        wires_i = 52'h5_1234_5678_9ABC;
        tick();
        check("rearm_wait", 64'(captured_o), 64'd0);
        tick();
        check("rearm_captured", 64'(captured_o), 64'd1);
        check("rearm_ts", 64'(ts_o), 64'd1);
        check_readout("rearm_rd", 52'h5_1234_5678_9ABC, 1'b0);

        // 5. arm and rd_req together, held high through the whole readout
        capture("cs", 52'h3_C3C3_5A5A_0001);
        check_readout("both_rd", 52'h3_C3C3_5A5A_0001, 1'b1);
        arm_i    = 1'b0;
        rd_req_i = 1'b0;
        tick();
        check("both_idle", 64'({armed_o, captured_o, sdo_valid_o}), 64'd0);

        // Timestamp saturation at 2**TSW-1
        wires_i      = '0;
        trig_mask_i  = '1;
        trig_value_i = 52'h0_0000_0000_00FF;
        arm_i = 1'b1;
        tick();
        arm_i = 1'b0;
        repeat (20) tick();
        check("sat_armed", 64'(armed_o), 64'd1);
        wires_i = 52'h0_0000_0000_00FF;
        tick();
        tick();
        check("sat_captured", 64'(captured_o), 64'd1);
        check("sat_ts", 64'(ts_o), 64'd15);
        check_readout("sat_rd", 52'h0_0000_0000_00FF, 1'b0);

        // 6. Reset after 10 bits of a readout, then a clean all-zero-mask run
        capture("cr", 52'hF_0000_0000_FFFF);
        rd_req_i = 1'b1;
        tick();
        rd_req_i = 1'b0;
        repeat (10) tick();
        check("mid_valid", 64'(sdo_valid_o), 64'd1);
        reset = 1'b1;
        tick();
        check("mid_rst", 64'({sdo_valid_o, done_o, armed_o, captured_o}), 64'd0);
        check("mid_rst_ts", 64'(ts_o), 64'd0);
        reset = 1'b0;
        tick();
        check("mid_post", 64'(sdo_valid_o), 64'd0);
        wires_i = 52'h7_7654_3210_ABCD;
        tick();
        trig_mask_i  = '0;
        trig_value_i = '0;
        arm_i = 1'b1;
        tick();
        arm_i = 1'b0;
        tick();
        check("z_captured", 64'(captured_o), 64'd1);
        check("z_ts", 64'(ts_o), 64'd0);
        check_readout("z_rd", 52'h7_7654_3210_ABCD, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
